interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Sits between up to NUM_SRC interrupt sources (SystemTimer and peripherals) and the CPU core.
- Sources hold a level IRQ and get one-cycle IACK/IEND pulses back; the CPU gets a single IRQ plus a vector, and answers with IACK/IEND pulses.
- Fixed-priority arbitration with per-source mask; one interrupt in service at a time (no nesting).

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16).
- VEC_BASE, 8'h20, vector of source 0; source i gets VEC_BASE+i.
- ID_W, clog2(NUM_SRC) min 1, width of source index (derived, not overridden).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- SRC_IRQ  input  NUM_SRC  level requests from sources, bit i = source i.
- SRC_MASK  input  NUM_SRC  1 = source enabled.
- SRC_IACK  output  NUM_SRC  one-cycle acknowledge pulse to the selected source.
- SRC_IEND  output  NUM_SRC  one-cycle end-of-service pulse to the selected source.
- CPU_IRQ  output  1  interrupt request to CPU.
- CPU_VECTOR  output  8  vector of the selected source, valid while CPU_IRQ or IN_SERVICE.
- CPU_IACK  input  1  CPU acknowledge, one-cycle pulse.
- CPU_IEND  input  1  CPU end of handler, one-cycle pulse.
- IN_SERVICE  output  1  high while a handler runs.

Behaviour:
- Reset (RESET low, async): state IDLE; CPU_IRQ=0, IN_SERVICE=0, SRC_IACK=0, SRC_IEND=0, CPU_VECTOR=8'h00, current id=0. Reset mid-service aborts silently with no IEND pulse.
- All outputs are registered.
- States: IDLE, REQUEST, SERVICE.
- IDLE: eligible = SRC_IRQ & SRC_MASK. If nonzero at edge k:
  - latch the lowest-index set bit as id.
  - CPU_VECTOR = VEC_BASE+id (mod 256).
  - CPU_IRQ=1 after edge k (1-cycle latency).
  - go to REQUEST.
- REQUEST: CPU_IRQ held high and id frozen; higher-priority arrivals, mask changes and the source dropping IRQ have no effect. On CPU_IACK sampled at an edge:
  - CPU_IRQ=0, IN_SERVICE=1.
  - SRC_IACK[id]=1 for exactly one cycle.
  - go to SERVICE.
- SERVICE: on CPU_IEND sampled at an edge:
  - SRC_IEND[id]=1 for one cycle, IN_SERVICE=0.
  - go to IDLE.
  - CPU_VECTOR holds its value until the next selection.
- IDLE re-arbitrates starting the cycle after SRC_IEND. Minimum gap between IEND pulse and the next CPU_IRQ rise is 1 cycle.
- Ignored inputs:
  - CPU_IACK outside REQUEST.
  - CPU_IEND outside SERVICE.
  - CPU_IACK and CPU_IEND together in REQUEST: IACK is taken, IEND is ignored.
- At most one bit of SRC_IACK|SRC_IEND is ever set, and never both outputs on the same cycle.
- Source contract: a source deasserts its IRQ after its IACK and may re-raise after its IEND. A source still high in IDLE is re-served, which is legal for level sources.

Decomposition:
- Shared package intc_pkg:
  - state enum (IDLE=2'd0, REQUEST=2'd1, SERVICE=2'd2).
  - VEC_W=8.
  - clog2 helper for ID_W.
- One sub-module, intc_priority_encoder: combinational, NUM_SRC-wide vector -> {valid, id} with lowest index winning. The FSM and pulse registers stay in the top.

Test Plan:
- Reset then single source: SRC_MASK=4'hF, SRC_IRQ=4'b0001 -> CPU_IRQ=1, CPU_VECTOR=8'h20 one cycle later; CPU_IACK pulse -> SRC_IACK=4'b0001 one cycle, IN_SERVICE=1; CPU_IEND -> SRC_IEND=4'b0001 one cycle, back to IDLE.
- Priority: SRC_IRQ=4'b1010 -> vector 8'h21; after IEND with bit 3 still high -> next CPU_IRQ with vector 8'h23.
- Masking/freeze: SRC_MASK=4'b1110 with SRC_IRQ=4'b0001 -> no CPU_IRQ. Raise bit 0 with mask 4'hF while REQUEST for id 2 -> vector stays 8'h22.
- Protocol violations: CPU_IEND in REQUEST and CPU_IACK in SERVICE -> no state change, no source pulses; simultaneous IACK+IEND in REQUEST -> only SRC_IACK pulses.
- Async reset asserted in SERVICE, mid-cycle -> outputs zero immediately, no SRC_IEND; after release with SRC_IRQ still high -> new request one cycle later.
- Timer-style periodic source on bit 0 at a 500-cycle period over 3 periods -> exactly 3 IACK and 3 IEND pulses on bit 0, with no spurious pulses on other bits.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// vector width and the index-width calculation.
package intc_pkg;

  localparam int VEC_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Bits needed to index n sources, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      r = ((32'd1 << i) < n) ? (i + 1) : r;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set bit of req wins.
module intc_priority_encoder
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      id = req[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority, non-nesting interrupt controller between level-triggered
// sources and a single CPU interrupt line with vector, all outputs registered.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int               NUM_SRC  = 4,
  parameter logic [VEC_W-1:0] VEC_BASE = 8'h20
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  input  logic [NUM_SRC-1:0] SRC_MASK,
  output logic [NUM_SRC-1:0] SRC_IACK,
  output logic [NUM_SRC-1:0] SRC_IEND,
  output logic               CPU_IRQ,
  output logic [VEC_W-1:0]   CPU_VECTOR,
  input  logic               CPU_IACK,
  input  logic               CPU_IEND,
  output logic               IN_SERVICE
);

  localparam int                 ID_W   = clog2_min1(NUM_SRC);
  localparam logic [NUM_SRC-1:0] ONE_LO = NUM_SRC'(1);

  state_t               state_r, state_s;
  logic [ID_W-1:0]      id_r, id_s;
  logic                 cpu_irq_r, cpu_irq_s;
  logic                 in_service_r, in_service_s;
  logic [VEC_W-1:0]     vector_r, vector_s;
  logic [NUM_SRC-1:0]   src_iack_r, src_iack_s;
  logic [NUM_SRC-1:0]   src_iend_r, src_iend_s;

  logic [NUM_SRC-1:0]   eligible_s;
  logic                 enc_valid_s;
  logic [ID_W-1:0]      enc_id_s;

  assign eligible_s = SRC_IRQ & SRC_MASK;

  intc_priority_encoder #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (eligible_s),
    .valid (enc_valid_s),
    .id    (enc_id_s)
  );

  // State and output registers; reset abandons any handler without an IEND.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r      <= IDLE;
      id_r         <= '0;
      cpu_irq_r    <= 1'b0;
      in_service_r <= 1'b0;
      vector_r     <= 8'h00;
      src_iack_r   <= '0;
      src_iend_r   <= '0;
    end else begin
      state_r      <= state_s;
      id_r         <= id_s;
      cpu_irq_r    <= cpu_irq_s;
      in_service_r <= in_service_s;
      vector_r     <= vector_s;
      src_iack_r   <= src_iack_s;
      src_iend_r   <= src_iend_s;
    end
  end

  // Next state; the id and vector only change on a fresh selection in IDLE.
  always_comb begin
    state_s      = state_r;
    id_s         = id_r;
    cpu_irq_s    = cpu_irq_r;
    in_service_s = in_service_r;
    vector_s     = vector_r;
    src_iack_s   = '0;
    src_iend_s   = '0;
    case (state_r)
      IDLE: begin
        if (enc_valid_s) begin
          id_s      = enc_id_s;
          vector_s  = VEC_BASE + VEC_W'(enc_id_s);
          cpu_irq_s = 1'b1;
          state_s   = REQUEST;
        end else begin
          cpu_irq_s = 1'b0;
        end
      end
      REQUEST: begin
        if (CPU_IACK) begin
          cpu_irq_s    = 1'b0;
          in_service_s = 1'b1;
          src_iack_s   = ONE_LO << id_r;
          state_s      = SERVICE;
        end else begin
          cpu_irq_s = 1'b1;
        end
      end
      SERVICE: begin
        if (CPU_IEND) begin
          in_service_s = 1'b0;
          src_iend_s   = ONE_LO << id_r;
          state_s      = IDLE;
        end else begin
          in_service_s = 1'b1;
        end
      end
      default: begin
        state_s      = IDLE;
        cpu_irq_s    = 1'b0;
        in_service_s = 1'b0;
      end
    endcase
  end

  assign SRC_IACK   = src_iack_r;
  assign SRC_IEND   = src_iend_r;
  assign CPU_IRQ    = cpu_irq_r;
  assign CPU_VECTOR = vector_r;
  assign IN_SERVICE = in_service_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed, table-driven bench for interrupt_controller with hand sequences
// for asynchronous reset in service and a periodic timer source.
module tb_interrupt_controller;

  logic       CLK;
  logic       RESET;
  logic [3:0] SRC_IRQ;
  logic [3:0] SRC_MASK;
  logic [3:0] SRC_IACK;
  logic [3:0] SRC_IEND;
  logic       CPU_IRQ;
  logic [7:0] CPU_VECTOR;
  logic       CPU_IACK;
  logic       CPU_IEND;
  logic       IN_SERVICE;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.NUM_SRC(4), .VEC_BASE(8'h20)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SRC_IRQ    (SRC_IRQ),
    .SRC_MASK   (SRC_MASK),
    .SRC_IACK   (SRC_IACK),
    .SRC_IEND   (SRC_IEND),
    .CPU_IRQ    (CPU_IRQ),
    .CPU_VECTOR (CPU_VECTOR),
    .CPU_IACK   (CPU_IACK),
    .CPU_IEND   (CPU_IEND),
    .IN_SERVICE (IN_SERVICE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Packed outputs: {cpu_irq, in_service, vector[7:0], iack[3:0], iend[3:0]}.
  typedef struct {
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic        iack;
    logic        iend;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic [3:0] irq, input logic [3:0] mask,
                              input logic ia, input logic ie,
                              input logic ci, input logic is,
                              input logic [7:0] vec,
                              input logic [3:0] sia, input logic [3:0] sie);
    vec_t v;
    v.irq  = irq;
    v.mask = mask;
    v.iack = ia;
    v.iend = ie;
    v.exp  = {ci, is, vec, sia, sie};
    return v;
  endfunction

  function automatic logic [17:0] outs();
    return {CPU_IRQ, IN_SERVICE, CPU_VECTOR, SRC_IACK, SRC_IEND};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    SRC_IRQ  = v.irq;
    SRC_MASK = v.mask;
    CPU_IACK = v.iack;
    CPU_IEND = v.iend;
    @(posedge CLK);
    @(negedge CLK);
    CPU_IACK = 1'b0;
    CPU_IEND = 1'b0;
    check(name, 32'(outs()), 32'(v.exp));
  endtask

  initial begin
    int   n_iack;
    int   n_iend;
    int   n_bad;
    logic acked;
    logic ended;

    //            irq      mask     ia    ie    cirq  insv  vec     siack    siend
    tbl[0]  = mk(4'b0001, 4'hF,    1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0000, 4'hF,    1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 4'b0001, 4'b0000);
    tbl[2]  = mk(4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0000, 4'hF,    1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 4'b0000, 4'b0001);
    tbl[4]  = mk(4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 4'b0000, 4'b0000);
    tbl[5]  = mk(4'b1010, 4'hF,    1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b1010, 4'hF,    1'b0, 1'b1, 1'b1, 1'b0, 8'h21, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b1000, 4'hF,    1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 4'b0010, 4'b0000);
    tbl[8]  = mk(4'b1000, 4'hF,    1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b1000, 4'hF,    1'b0, 1'b1, 1'b0, 1'b0, 8'h21, 4'b0000, 4'b0010);
    tbl[10] = mk(4'b1000, 4'hF,    1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 4'b0000, 4'b0000);
    tbl[11] = mk(4'b0000, 4'hF,    1'b1, 1'b1, 1'b0, 1'b1, 8'h23, 4'b1000, 4'b0000);
    tbl[12] = mk(4'b0000, 4'hF,    1'b0, 1'b1, 1'b0, 1'b0, 8'h23, 4'b0000, 4'b1000);
    tbl[13] = mk(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23, 4'b0000, 4'b0000);
    tbl[14] = mk(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23, 4'b0000, 4'b0000);
    tbl[15] = mk(4'b0100, 4'hF,    1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 4'b0000, 4'b0000);
    tbl[16] = mk(4'b0101, 4'hF,    1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 4'b0000, 4'b0000);
    tbl[17] = mk(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 4'b0000, 4'b0000);
    tbl[18] = mk(4'b0001, 4'hF,    1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'b0100, 4'b0000);
    tbl[19] = mk(4'b0001, 4'hF,    1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 4'b0000, 4'b0000);

    RESET    = 1'b0;
    SRC_IRQ  = 4'b0000;
    SRC_MASK = 4'hF;
    CPU_IACK = 1'b0;
    CPU_IEND = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_state", 32'(outs()), 32'd0);
    RESET = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset in SERVICE (id 2), between clock edges.
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset_now", 32'(outs()), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("async_reset_no_iend", 32'(outs()), 32'd0);
    RESET = 1'b1;
    apply(mk(4'b0001, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 4'b0000, 4'b0000), "post_reset_req");
    apply(mk(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 4'b0001, 4'b0000), "post_reset_iack");
    apply(mk(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 4'b0000, 4'b0001), "post_reset_iend");

    // Periodic timer on source 0 served by a simple CPU handshake.
    n_iack = 0;
    n_iend = 0;
    n_bad  = 0;
    acked  = 1'b0;
    ended  = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 500; c++) begin
        if (c == 0) begin
          SRC_IRQ = 4'b0001;
          acked   = 1'b0;
          ended   = 1'b0;
        end
        CPU_IACK = CPU_IRQ && !acked;
        acked    = acked || CPU_IACK;
        CPU_IEND = IN_SERVICE && !ended && (c >= 100);
        ended    = ended || CPU_IEND;
        @(posedge CLK);
        @(negedge CLK);
        if (SRC_IACK == 4'b0001) begin
          n_iack++;
          SRC_IRQ = 4'b0000;
        end
        if (SRC_IEND == 4'b0001) n_iend++;
        if (((SRC_IACK & 4'b1110) != 4'b0000) || ((SRC_IEND & 4'b1110) != 4'b0000) ||
            ((SRC_IACK != 4'b0000) && (SRC_IEND != 4'b0000))) n_bad++;
      end
    end
    CPU_IACK = 1'b0;
    CPU_IEND = 1'b0;
    check("timer_iack_count", 32'(n_iack), 32'd3);
    check("timer_iend_count", 32'(n_iend), 32'd3);
    check("timer_spurious", 32'(n_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
